// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the normalize/round controller.
package fp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int FLAG_NX = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 2;
  localparam int FLAG_ZR = 3;

  localparam int          BIAS       = 127;
  localparam int          EXP_MAX    = 255;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  // Internal exponent is one bit wider than the port so in_exp=1023 can still carry.
  localparam int EXP_W = 11;

endpackage

// File: rtl/fp_round_core.sv
// Combinational rounding, carry handling and IEEE-754 single packing.
module fp_round_core
  import fp_ctrl_pkg::*;
#(
  parameter int DATA_W = 48
) (
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [DATA_W-1:0] mag_i,
  input  logic [1:0]        mode_i,
  output logic [31:0]       data_o,
  output logic [3:0]        flags_o
);

  logic             hidden, guard, sticky, inc, inexact, overflow, to_inf;
  logic [22:0]      frac, frac_r;
  logic [24:0]      sum;
  logic [EXP_W-1:0] exp_f;

  always_comb begin
    hidden  = mag_i[DATA_W-1];
    frac    = mag_i[DATA_W-2 -: 23];
    guard   = mag_i[DATA_W-25];
    sticky  = |mag_i[DATA_W-26:0];
    inexact = guard | sticky;

    case (mode_i)
      RM_RNE:  inc = guard & (sticky | frac[0]);
      RM_RUP:  inc = ~sign_i & inexact;
      RM_RDN:  inc = sign_i & inexact;
      default: inc = 1'b0;
    endcase

    sum = {1'b0, hidden, frac} + {24'd0, inc};

    if (sum[24]) begin
      exp_f  = exp_i + 11'd1;
      frac_r = '0;
    end else if (sum[23]) begin
      // A denormal that rounds up into the hidden bit lands at the smallest normal exponent.
      exp_f  = hidden ? exp_i : 11'd1;
      frac_r = sum[22:0];
    end else begin
      exp_f  = '0;
      frac_r = sum[22:0];
    end

    overflow = (exp_f >= 11'(EXP_MAX));
    to_inf   = (mode_i == RM_RNE) || (mode_i == RM_RUP && !sign_i) ||
               (mode_i == RM_RDN && sign_i);

    if (overflow) begin
      inexact = 1'b1;
      data_o  = to_inf ? {sign_i, 8'hFF, 23'd0} : {sign_i, MAX_FINITE[30:0]};
    end else begin
      data_o  = {sign_i, exp_f[7:0], frac_r};
    end

    flags_o          = '0;
    flags_o[FLAG_NX] = inexact;
    flags_o[FLAG_OF] = overflow;
    flags_o[FLAG_UF] = inexact && (exp_f == '0);
    flags_o[FLAG_ZR] = (data_o[30:0] == '0);
  end

endmodule

// File: rtl/fp_norm_round_ctrl.sv
// Multi-cycle normalizer feeding a rounding/packing core, with valid/ready handshakes.
module fp_norm_round_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int DATA_W     = 48,
  parameter int SHIFT_STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [9:0]        in_exp,
  input  logic [DATA_W-1:0] in_mag,
  input  logic [1:0]        rnd_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_flags
);

  state_e            state_q, state_d;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q, exp_sh;
  logic [DATA_W-1:0] mag_q, mag_sh;
  logic [1:0]        mode_q;
  logic [31:0]       out_data_q, rc_data;
  logic [3:0]        out_flags_q, rc_flags;
  logic              norm_done;
  int                lz, shamt;

  // Shift by the smallest of step size, leading zeros and exponent headroom.
  always_comb begin
    lz = DATA_W;
    for (int i = 0; i < DATA_W; i++) begin
      if (mag_q[i]) lz = DATA_W - 1 - i;
    end
    shamt = SHIFT_STEP;
    if (lz < shamt) shamt = lz;
    if (int'(exp_q) - 1 < shamt) shamt = int'(exp_q) - 1;
    norm_done = mag_q[DATA_W-1] || (mag_q == '0) || (exp_q <= 11'd1);
    mag_sh    = mag_q << shamt;
    exp_sh    = exp_q - EXP_W'(shamt);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = NORM;
      NORM:    if (norm_done) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == OUT);
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      sign_q <= in_sign;
      exp_q  <= (in_exp == 10'd0) ? 11'd1 : {1'b0, in_exp};
      mag_q  <= in_mag;
      mode_q <= rnd_mode;
    end else if (state_q == NORM && !norm_done) begin
      mag_q  <= mag_sh;
      exp_q  <= exp_sh;
    end
  end

  fp_round_core #(.DATA_W(DATA_W)) u_round (
    .sign_i  (sign_q),
    .exp_i   (exp_q),
    .mag_i   (mag_q),
    .mode_i  (mode_q),
    .data_o  (rc_data),
    .flags_o (rc_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (state_q == ROUND) begin
      out_data_q  <= rc_data;
      out_flags_q <= rc_flags;
    end
  end

  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_norm_round_ctrl.sv
// Directed bench for fp_norm_round_ctrl with DATA_W=48, SHIFT_STEP=8.
module tb_fp_norm_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mag;
  logic [1:0]  rnd_mode;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_norm_round_ctrl #(.DATA_W(48), .SHIFT_STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mag    (in_mag),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Offers one operand; returns at the falling edge just after the transfer edge.
  task automatic launch(input string tag, input logic s, input logic [9:0] e,
                        input logic [47:0] m, input logic [1:0] md);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 64'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mag   = m;
    rnd_mode = md;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                        input logic [47:0] m, input logic [1:0] md,
                        input logic [31:0] xd, input logic [3:0] xf, input int xlat);
    int n;
    out_ready = 1'b1;
    launch(tag, s, e, m, md);
    wait_valid(n);
    chk({tag, "_latency"}, 64'(n), 64'(xlat));
    chk({tag, "_data"}, out_data, 64'(xd));
    chk({tag, "_flags"}, out_flags, 64'(xf));
    @(negedge clk);
    chk({tag, "_out_done"}, out_valid, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mag = '0;
    rnd_mode = 2'd0; out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 64'd0);
    chk("reset_out_valid", out_valid, 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_flags", out_flags, 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_release_ready", in_ready, 64'd1);

    run_op("unit",        1'b0, 10'd127, 48'h8000_0000_0000, 2'd0, 32'h3F80_0000, 4'h0, 3);
    run_op("norm2",       1'b0, 10'd143, 48'h0000_8000_0000, 2'd0, 32'h3F80_0000, 4'h0, 5);
    run_op("norm_denorm", 1'b0, 10'd3,   48'h0000_8000_0000, 2'd0, 32'h0000_0200, 4'h0, 4);
    run_op("norm4",       1'b0, 10'd127, 48'h0000_0040_0000, 2'd0, 32'h3300_0000, 4'h0, 7);
    run_op("tie_even",    1'b0, 10'd127, 48'h8000_0080_0000, 2'd0, 32'h3F80_0000, 4'h1, 3);
    run_op("tie_odd",     1'b0, 10'd127, 48'h8000_0180_0000, 2'd0, 32'h3F80_0002, 4'h1, 3);
    run_op("tie_rtz",     1'b0, 10'd127, 48'h8000_0180_0000, 2'd1, 32'h3F80_0001, 4'h1, 3);
    run_op("carry",       1'b0, 10'd127, 48'hFFFF_FF80_0000, 2'd0, 32'h4000_0000, 4'h1, 3);
    run_op("ovf_rne",     1'b0, 10'd254, 48'hFFFF_FFFF_FFFF, 2'd0, 32'h7F80_0000, 4'h3, 3);
    run_op("ovf_rtz",     1'b0, 10'd254, 48'hFFFF_FFFF_FFFF, 2'd1, 32'h7F7F_FFFF, 4'h1, 3);
    run_op("neg_zero",    1'b1, 10'd127, 48'h0000_0000_0000, 2'd0, 32'h8000_0000, 4'h8, 3);
    run_op("rdn_neg",     1'b1, 10'd127, 48'h8000_0000_0001, 2'd3, 32'hBF80_0001, 4'h1, 3);
    run_op("rup_pos",     1'b0, 10'd127, 48'h8000_0000_0001, 2'd2, 32'h3F80_0001, 4'h1, 3);
    run_op("rup_neg",     1'b1, 10'd127, 48'h8000_0000_0001, 2'd2, 32'hBF80_0000, 4'h1, 3);
    run_op("rdn_pos",     1'b0, 10'd127, 48'h8000_0000_0001, 2'd3, 32'h3F80_0000, 4'h1, 3);
    run_op("underflow",   1'b0, 10'd1,   48'h0000_0080_0001, 2'd0, 32'h0000_0001, 4'h5, 3);
    run_op("denorm_up",   1'b0, 10'd1,   48'h7FFF_FF80_0000, 2'd0, 32'h0080_0000, 4'h1, 3);
    run_op("tiny_zero",   1'b0, 10'd20,  48'h0000_0000_0001, 2'd0, 32'h0000_0000, 4'hD, 6);
    run_op("tiny_rup",    1'b0, 10'd20,  48'h0000_0000_0001, 2'd2, 32'h0000_0001, 4'h5, 6);
    run_op("exp0",        1'b0, 10'd0,   48'h8000_0000_0000, 2'd0, 32'h0080_0000, 4'h0, 3);
    run_op("bigexp_rne",  1'b0, 10'd300, 48'h8000_0000_0000, 2'd0, 32'h7F80_0000, 4'h3, 3);
    run_op("bigexp_rtz",  1'b0, 10'd300, 48'h8000_0000_0000, 2'd1, 32'h7F7F_FFFF, 4'h3, 3);
    run_op("bigexp_rupn", 1'b1, 10'd300, 48'h8000_0000_0000, 2'd2, 32'hFF7F_FFFF, 4'h3, 3);
    run_op("bigexp_rdnn", 1'b1, 10'd300, 48'h8000_0000_0000, 2'd3, 32'hFF80_0000, 4'h3, 3);

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    launch("hold", 1'b0, 10'd127, 48'h8000_0180_0000, 2'd0);
    wait_valid(n);
    chk("hold_latency", 64'(n), 64'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 64'd1);
      chk("hold_data", out_data, 64'h3F80_0002);
      chk("hold_flags", out_flags, 64'h1);
      chk("hold_in_ready", in_ready, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", out_valid, 64'd0);
    chk("hold_release_ready", in_ready, 64'd1);

    // Reset while normalizing discards the operation.
    launch("rst_norm", 1'b0, 10'd143, 48'h0000_8000_0000, 2'd0);
    chk("rst_norm_busy", in_ready, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_norm_valid", out_valid, 64'd0);
    chk("rst_norm_ready_held", in_ready, 64'd0);
    chk("rst_norm_data", out_data, 64'd0);
    chk("rst_norm_flags", out_flags, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_norm_ready", in_ready, 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_norm_discarded", 64'(seen), 64'd0);

    run_op("after_rst", 1'b0, 10'd127, 48'h8000_0000_0000, 2'd0, 32'h3F80_0000, 4'h0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_round_ctrl.md
FP_NORM_ROUND_CTRL -- requirements
Module: fp_norm_round_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 48, unnormalized magnitude width; legal range 26..64.
REQ-002 SHALL have parameter SHIFT_STEP, default 8, maximum left-shift bits per normalize cycle.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; reset is synchronous and active-high.
REQ-005 in_valid  in  1  operand offered.
REQ-006 in_ready  out  1  block can accept; an operand transfers when in_valid && in_ready.
REQ-007 in_sign  in  1  result sign.
REQ-008 in_exp  in  10  unsigned biased exponent of in_mag's MSB position; 0 is treated as 1.
REQ-009 in_mag  in  DATA_W  magnitude, binary point after bit DATA_W-1.
REQ-010 rnd_mode  in  2  0 = nearest-even, 1 = toward zero, 2 = toward +inf, 3 = toward -inf; sampled on transfer.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts; result transfers when out_valid && out_ready.
REQ-013 out_data  out  32  IEEE-754 single result.
REQ-014 out_flags  out  4  [0] inexact, [1] overflow, [2] underflow, [3] zero.

Function
REQ-015 FSM states SHALL be IDLE, NORM, ROUND and OUT.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low; a transfer loads sign/exp/mag/mode and moves to NORM.
REQ-017 NORM: while mag[DATA_W-1]=0, mag!=0 and exp>1, SHALL shift mag left by min(SHIFT_STEP, leading zeros, exp-1) and decrement exp by the same amount each cycle.
REQ-018 NORM SHALL move to ROUND the cycle after mag[DATA_W-1]=1, exp=1 or mag=0 holds.
REQ-019 Rounding fields: hidden = mag[DATA_W-1], fraction = mag[DATA_W-2:DATA_W-24], guard = mag[DATA_W-25], sticky = OR of mag[DATA_W-26:0].
REQ-020 Increment: RNE = guard && (sticky || fraction LSB); RTZ = never; +inf = !sign && (guard||sticky); -inf = sign && (guard||sticky).
REQ-021 {hidden, fraction} + increment SHALL be 25 bits wide; a carry-out gives fraction 0 and exp+1; a hidden bit set from 0 gives an exponent field of 1.
REQ-022 The exponent field SHALL be 0 when the hidden bit after rounding is 0 (denormal or zero).
REQ-023 Exponent field >= 255 SHALL raise overflow and inexact; result = inf for RNE, for +inf with positive sign and for -inf with negative sign; otherwise max finite 0x7F7FFFFF with sign.
REQ-024 inexact = guard||sticky; underflow = inexact && exponent field 0; zero = result magnitude 0; mag=0 SHALL give signed zero.
REQ-025 ROUND SHALL register out_data/out_flags in one cycle and move to OUT; out_valid SHALL be 1 exactly in OUT.
REQ-026 Latency from transfer edge to out_valid SHALL be 3 + number of shifting NORM cycles (3 when already normalized).
REQ-027 out_data/out_flags SHALL hold stable in OUT until out_ready; on the out transfer the FSM SHALL go to IDLE (one idle bubble between operands).
REQ-028 in_exp values above 254 SHALL propagate into the overflow path unchanged.

Reset
REQ-029 rst SHALL force IDLE on the next edge from any state, discarding any operation in flight.
REQ-030 After reset: out_valid=0, out_data=0, out_flags=0; in_ready=0 while rst=1 and 1 on the first cycle after rst=0.

Structure
REQ-031 Package fp_ctrl_pkg SHALL hold the FSM state enum, rounding-mode constants, flag bit indices, BIAS=127, EXP_MAX=255 and MAX_FINITE=0x7F7FFFFF.
REQ-032 Rounding, carry handling and packing SHALL be a combinational sub-module fp_round_core; FSM, registers and shifter stay in the top module.

Verification (DATA_W=48, SHIFT_STEP=8)
REQ-033 Unit value: exp=127, mag=0x800000000000, RNE -> 0x3F800000, flags 0, out_valid 3 cycles after transfer.
REQ-034 Normalize: exp=143, mag=0x000080000000 -> 0x3F800000 after 5 cycles; exp=3, mag=0x000080000000 -> exponent field 0, denormal result.
REQ-035 Ties: mag=0x800000800000 RNE -> 0x3F800000 with inexact; mag=0x800001800000 RNE -> 0x3F800002; same with mode 1 -> 0x3F800001.
REQ-036 Carry and overflow: exp=127, mag=0xFFFFFF800000, RNE -> 0x40000000 with inexact; exp=254, mag=0xFFFFFFFFFFFF: RNE -> 0x7F800000 with overflow and inexact; RTZ -> 0x7F7FFFFF.
REQ-037 Zero and sign: mag=0, sign=1 -> 0x80000000 with zero flag; sign=1, mode 3, mag=0x800000000001 -> fraction LSB incremented.
REQ-038 Handshake and reset: out_ready low for 4 cycles -> out_data stable and in_ready 0; rst asserted in NORM -> out_valid 0 on next edge and in_ready 1 the cycle after rst drops.
